// File: rtl/onehot_dec_pkg.sv
// onehot_dec_pkg: shared state encoding and default parameters for the pulse decoder
package onehot_dec_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  localparam int DEF_N = 4;
  localparam int DEF_PULSE_LEN = 2;
  localparam int DEF_GAP_LEN = 1;
endpackage

// File: rtl/onehot_pulse_decoder_if.sv
// onehot_pulse_decoder_if: request and pulse bus between a requester and the decoder
interface onehot_pulse_decoder_if import onehot_dec_pkg::*; #(
  parameter int N = DEF_N,
  parameter int W = $clog2(N)
);
  logic in_valid, in_ready, in_en, y_valid, err;
  logic [W-1:0] in_idx;
  logic [N-1:0] y;
  modport master (output in_valid, in_idx, in_en, input in_ready, y, y_valid, err);
  modport slave (input in_valid, in_idx, in_en, output in_ready, y, y_valid, err);
endinterface

// File: rtl/onehot_dec_core.sv
// onehot_dec_core: combinational binary-to-one-hot decode with an in-range flag
module onehot_dec_core #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         in_range
);
  assign in_range = 32'(idx) < N;
  assign onehot = in_range ? N'(1) << idx : '0;
endmodule

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: timed one-hot pulse with idle gap; ONEHOT_DEC_RANGE_CHK_EN drops out-of-range requests and raises err
module onehot_pulse_decoder import onehot_dec_pkg::*; #(
  parameter int N = DEF_N,
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int GAP_LEN = DEF_GAP_LEN
) (
  input logic clk,
  input logic rst,
  onehot_pulse_decoder_if.slave bus
);
  localparam int CW = $clog2((PULSE_LEN > GAP_LEN ? PULSE_LEN : GAP_LEN) + 1);
`ifdef ONEHOT_DEC_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0] y, y_n, dec;
  logic yv, yv_n, er, er_n, in_range, take, fire;
  onehot_dec_core #(.N(N)) u_core (.idx(bus.in_idx), .onehot(dec), .in_range(in_range));
  assign bus.in_ready = state == IDLE;
  assign take = bus.in_valid && bus.in_ready && bus.in_en;
  assign fire = take && (in_range || !CHK);
  assign bus.y = y;
  assign bus.y_valid = yv;
  assign bus.err = CHK && er;
  // next state, counter reload on state entry, next registered outputs
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    y_n = y;
    yv_n = yv;
    er_n = CHK && take && !in_range;
    case (state)
      IDLE: if (fire) begin
        state_n = PULSE;
        cnt_n = CW'(PULSE_LEN);
        y_n = dec;
        yv_n = 1'b1;
      end
      PULSE: if (cnt == CW'(1)) begin
        state_n = GAP_LEN > 0 ? GAP : IDLE;
        cnt_n = CW'(GAP_LEN);
        y_n = '0;
        yv_n = 1'b0;
      end else cnt_n = cnt - CW'(1);
      GAP: if (cnt == CW'(1)) begin
        state_n = IDLE;
        cnt_n = '0;
      end else cnt_n = cnt - CW'(1);
      default: state_n = IDLE;
    endcase
  end
  // state, counter and output registers; reset overrides any concurrent accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      y <= '0;
      yv <= 1'b0;
      er <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      y <= y_n;
      yv <= yv_n;
      er <= er_n;
    end
  end
endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb_onehot_pulse_decoder: randomized scoreboard check of three decoder configurations
module tb_onehot_pulse_decoder;
`ifdef ONEHOT_DEC_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int N = g == 2 ? 5 : 4;
    localparam int P = g == 1 ? 3 : 2;
    localparam int G = g == 1 ? 0 : 1;
    localparam int W = $clog2(N);
    logic rst;
    bit fin = 1'b0;
    int busy = 0;
    int qs [$];
    logic [N-1:0] qy [$];
    int qe [$];
    onehot_pulse_decoder_if #(.N(N)) bus ();
    onehot_pulse_decoder #(.N(N), .PULSE_LEN(P), .GAP_LEN(G)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial begin
      logic [N-1:0] ey;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_en = 1'b0;
      bus.in_idx = '0;
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        chk($sformatf("cfg%0d in_ready", g), int'(bus.in_ready), int'(busy == 0));
        rst = i < 2 || (i > 10 && i < 580 && $urandom_range(0, 39) == 0);
        bus.in_valid = i < 580 && $urandom_range(0, 9) < 7;
        bus.in_en = $urandom_range(0, 9) < 8;
        bus.in_idx = W'($urandom_range(0, (1 << W) - 1));
        if (rst) busy = 0;
        else if (busy > 0) busy--;
        else if (bus.in_valid && bus.in_en) begin
          for (int k = 0; k < N; k++) ey[k] = k == int'(bus.in_idx);
          if (int'(bus.in_idx) >= N && CHK) qe.push_back(cyc + 1);
          else begin
            qs.push_back(cyc + 1);
            qy.push_back(ey);
            busy = P + G;
          end
        end
      end
      chk($sformatf("cfg%0d leftover", g), qs.size() + qe.size(), 0);
      fin = 1'b1;
    end
    initial begin
      bit r;
      bit act;
      bit ee;
      int len;
      logic [N-1:0] cy;
      act = 1'b0;
      len = 0;
      cy = '0;
      forever begin
        @(posedge clk);
        r = rst;
        @(negedge clk);
        if (r) begin
          act = 1'b0;
          chk($sformatf("cfg%0d rst_y", g), int'(bus.y), 0);
          chk($sformatf("cfg%0d rst_y_valid", g), int'(bus.y_valid), 0);
          chk($sformatf("cfg%0d rst_err", g), int'(bus.err), 0);
        end else begin
          ee = qe.size() > 0 && qe[0] == cyc;
          if (ee) void'(qe.pop_front());
          chk($sformatf("cfg%0d err", g), int'(bus.err), int'(ee));
          if (!bus.y_valid) chk($sformatf("cfg%0d y_idle", g), int'(bus.y), 0);
          if (bus.y_valid && !act) begin
            chk($sformatf("cfg%0d pulse_expected", g), qs.size(), 1);
            if (qs.size() > 0) begin
              chk($sformatf("cfg%0d pulse_start", g), cyc, qs.pop_front());
              cy = qy.pop_front();
              chk($sformatf("cfg%0d pulse_y", g), int'(bus.y), int'(cy));
            end
            act = 1'b1;
            len = 1;
          end else if (bus.y_valid) begin
            len++;
            chk($sformatf("cfg%0d pulse_hold_y", g), int'(bus.y), int'(cy));
          end else if (act) begin
            chk($sformatf("cfg%0d pulse_len", g), len, P);
            act = 1'b0;
          end else if (qs.size() > 0 && qs[0] <= cyc) begin
            chk($sformatf("cfg%0d pulse_missing", g), int'(bus.y_valid), 1);
            void'(qs.pop_front());
            void'(qy.pop_front());
          end
        end
      end
    end
  end
  initial begin
    fork
      wait (u[0].fin && u[1].fin && u[2].fin);
      #100000;
    join_any
    disable fork;
    chk("timeout", int'(u[0].fin && u[1].fin && u[2].fin), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
